// File: rtl/monitoreo_multicanal.sv
// monitoreo_multicanal: NCANALES independent temperature supervisors (persistence, hysteresis, sticky fault); MONITOREO_HISTERESIS_EN enables recovery margin.
// Latency: outputs follow on the 2nd rising edge after the edge that captured the deciding sample.
// Backpressure: none; every channel accepts a sample every cycle.
module monitoreo_multicanal #(
  parameter int ANCHO          = 11,
  parameter int NCANALES       = 4,
  parameter int PERSISTENCIA   = 5,
  parameter int TEMP_MIN       = 15,
  parameter int TEMP_MAX       = 30,
  parameter int HISTERESIS     = 2,
  parameter int LIM_SENSOR_MIN = -40,
  parameter int LIM_SENSOR_MAX = 125
) (
  input  logic                         clk,
  input  logic                         arst,
  input  logic [NCANALES*ANCHO-1:0]    temp_entrada,
  input  logic [NCANALES-1:0]          muestra_valida,
  input  logic [NCANALES-1:0]          borrar_falla,
  output logic [NCANALES-1:0]          calefactor,
  output logic [NCANALES-1:0]          ventilador,
  output logic [NCANALES-1:0]          alerta,
  output logic                         alerta_global,
  output logic [2*NCANALES-1:0]        estado_actual
);

  typedef enum logic [1:0] {NORMAL = 2'b00, FRIO = 2'b01, CALIENTE = 2'b10, FALLA = 2'b11} estado_t;
  typedef enum logic [1:0] {DENTRO = 2'b00, BAJO = 2'b01, ALTO = 2'b10, FUERA = 2'b11} clase_t;

  localparam int CW = $clog2(PERSISTENCIA + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(PERSISTENCIA);

  // All limits are held in ANCHO+1 bits so sample comparisons cannot overflow.
  localparam logic signed [ANCHO:0] SEN_MIN = (ANCHO+1)'(LIM_SENSOR_MIN);
  localparam logic signed [ANCHO:0] SEN_MAX = (ANCHO+1)'(LIM_SENSOR_MAX);
  localparam logic signed [ANCHO:0] T_MIN   = (ANCHO+1)'(TEMP_MIN);
  localparam logic signed [ANCHO:0] T_MAX   = (ANCHO+1)'(TEMP_MAX);
`ifdef MONITOREO_HISTERESIS_EN
  localparam logic signed [ANCHO:0] REC_FRIO = (ANCHO+1)'(TEMP_MIN + HISTERESIS);
  localparam logic signed [ANCHO:0] REC_CAL  = (ANCHO+1)'(TEMP_MAX - HISTERESIS);
`else
  // Margin disabled: HISTERESIS stays in the parameter list but contributes nothing.
  localparam logic signed [ANCHO:0] REC_FRIO = (ANCHO+1)'(TEMP_MIN + 0 * HISTERESIS);
  localparam logic signed [ANCHO:0] REC_CAL  = (ANCHO+1)'(TEMP_MAX - 0 * HISTERESIS);
`endif

  logic [2*NCANALES-1:0] est_w;
  logic [NCANALES-1:0]   falla_w;

  for (genvar i = 0; i < NCANALES; i++) begin : g_canal
    logic signed [ANCHO-1:0] temp_reg;
    logic signed [ANCHO:0]   temp_ext;
    logic                    pendiente;
    logic [CW-1:0]           cnt, cnt_nxt;
    clase_t                  clase, clase_prev, clase_prev_nxt;
    estado_t                 estado, estado_nxt;
    logic                    lleno;

    assign temp_ext         = {temp_reg[ANCHO-1], temp_reg};
    assign est_w[2*i +: 2]  = estado;
    assign falla_w[i]       = (estado == FALLA);

    always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
        temp_reg   <= '0;
        pendiente  <= 1'b0;
        cnt        <= '0;
        clase_prev <= DENTRO;
        estado     <= NORMAL;
      end else begin
        pendiente <= muestra_valida[i];
        if (muestra_valida[i]) temp_reg <= temp_entrada[i*ANCHO +: ANCHO];
        cnt        <= cnt_nxt;
        clase_prev <= clase_prev_nxt;
        estado     <= estado_nxt;
      end
    end

    always_comb begin
      clase = DENTRO;
      if (temp_ext < SEN_MIN || temp_ext > SEN_MAX) clase = FUERA;
      else if (temp_ext > T_MAX)                    clase = ALTO;
      else if (temp_ext < T_MIN)                    clase = BAJO;
    end

    always_comb begin
      cnt_nxt        = cnt;
      clase_prev_nxt = clase_prev;
      estado_nxt     = estado;
      lleno          = 1'b0;
      if (pendiente) begin
        clase_prev_nxt = clase;
        if (clase == DENTRO)          cnt_nxt = '0;
        else if (clase == clase_prev) cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
        else                          cnt_nxt = CW'(1);
        lleno = (cnt_nxt == CNT_MAX);
        case (estado)
          NORMAL: begin
            if (lleno && clase == ALTO)       estado_nxt = CALIENTE;
            else if (lleno && clase == BAJO)  estado_nxt = FRIO;
            else if (lleno && clase == FUERA) estado_nxt = FALLA;
          end
          FRIO: begin
            if (lleno && clase == FUERA)      estado_nxt = FALLA;
            else if (lleno && clase == ALTO)  estado_nxt = CALIENTE;
            else if (temp_ext >= REC_FRIO)    estado_nxt = NORMAL;
          end
          CALIENTE: begin
            if (lleno && clase == FUERA)      estado_nxt = FALLA;
            else if (lleno && clase == BAJO)  estado_nxt = FRIO;
            else if (temp_ext <= REC_CAL)     estado_nxt = NORMAL;
          end
          default: begin
            // Sticky fault: only a clear request alongside a readable sample releases it.
            if (borrar_falla[i] && clase != FUERA) begin
              estado_nxt = NORMAL;
              cnt_nxt    = '0;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      calefactor    <= '0;
      ventilador    <= '0;
      alerta        <= '0;
      alerta_global <= 1'b0;
      estado_actual <= '0;
    end else begin
      for (int j = 0; j < NCANALES; j++) begin
        calefactor[j] <= (est_w[2*j +: 2] == FRIO);
        ventilador[j] <= (est_w[2*j +: 2] == CALIENTE);
        alerta[j]     <= falla_w[j];
      end
      alerta_global <= |falla_w;
      estado_actual <= est_w;
    end
  end

endmodule

// File: tb/tb_monitoreo_multicanal.sv
// Bench for monitoreo_multicanal: a behavioural reference model feeds a scoreboard queue,
// compared one cycle after each push against the registered outputs.
module tb_monitoreo_multicanal;

  localparam int W = 11, NC = 4, P = 5;
  localparam int TMIN = 15, TMAX = 30, SMIN = -40, SMAX = 125;
`ifdef MONITOREO_HISTERESIS_EN
  localparam int RF = TMIN + 2, RC = TMAX - 2;
`else
  localparam int RF = TMIN, RC = TMAX;
`endif

  logic              clk = 1'b0;
  logic              arst;
  logic [NC*W-1:0]   temp_entrada;
  logic [NC-1:0]     muestra_valida, borrar_falla;
  logic [NC-1:0]     calefactor, ventilador, alerta;
  logic              alerta_global;
  logic [2*NC-1:0]   estado_actual;

  monitoreo_multicanal dut (
    .clk(clk), .arst(arst), .temp_entrada(temp_entrada), .muestra_valida(muestra_valida),
    .borrar_falla(borrar_falla), .calefactor(calefactor), .ventilador(ventilador),
    .alerta(alerta), .alerta_global(alerta_global), .estado_actual(estado_actual)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2*NC-1:0] est;
    logic [NC-1:0]   cal, ven, ale;
    logic            glob;
  } sal_t;

  sal_t sb_q[$];
  int   n_cmp = 0, n_err = 0;
  int   m_est[NC], m_cnt[NC], m_prev[NC], m_tmp[NC];
  bit   m_pend[NC];

  task automatic check_dat(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // 3 = out of sensor range, 2 = hot, 1 = cold, 0 = comfortable
  function automatic int clasif(input int t);
    if (t < SMIN || t > SMAX) return 3;
    if (t > TMAX) return 2;
    if (t < TMIN) return 1;
    return 0;
  endfunction

  task automatic modelo_reset();
    for (int c = 0; c < NC; c++) begin
      m_est[c] = 0; m_cnt[c] = 0; m_prev[c] = 0; m_tmp[c] = 0; m_pend[c] = 1'b0;
    end
  endtask

  // Processes the sample captured last cycle (with this cycle's clear), then captures the new one.
  task automatic modelo_paso(input logic [NC*W-1:0] t, input logic [NC-1:0] v, input logic [NC-1:0] b);
    int k, nxt;
    bit full;
    for (int c = 0; c < NC; c++) begin
      if (m_pend[c]) begin
        k = clasif(m_tmp[c]);
        if (k == 0)              m_cnt[c] = 0;
        else if (k == m_prev[c]) m_cnt[c] = (m_cnt[c] < P) ? m_cnt[c] + 1 : P;
        else                     m_cnt[c] = 1;
        m_prev[c] = k;
        full = (m_cnt[c] == P);
        nxt  = m_est[c];
        case (m_est[c])
          0: if (full) nxt = (k == 2) ? 2 : (k == 1) ? 1 : (k == 3) ? 3 : 0;
          1: if (full && k == 3) nxt = 3; else if (full && k == 2) nxt = 2; else if (m_tmp[c] >= RF) nxt = 0;
          2: if (full && k == 3) nxt = 3; else if (full && k == 1) nxt = 1; else if (m_tmp[c] <= RC) nxt = 0;
          default: if (b[c] && k != 3) begin nxt = 0; m_cnt[c] = 0; end
        endcase
        m_est[c] = nxt;
      end
      m_pend[c] = v[c];
      if (v[c]) m_tmp[c] = $signed(t[c*W +: W]);
    end
  endtask

  function automatic sal_t esperado();
    sal_t e;
    e = '0;
    for (int c = 0; c < NC; c++) begin
      e.est[2*c +: 2] = 2'(m_est[c]);
      e.cal[c] = (m_est[c] == 1);
      e.ven[c] = (m_est[c] == 2);
      e.ale[c] = (m_est[c] == 3);
    end
    e.glob = |e.ale;
    return e;
  endfunction

  task automatic comparar(input sal_t e);
    check_dat("estado_actual", 32'(estado_actual), 32'(e.est));
    check_dat("calefactor",    32'(calefactor),    32'(e.cal));
    check_dat("ventilador",    32'(ventilador),    32'(e.ven));
    check_dat("alerta",        32'(alerta),        32'(e.ale));
    check_dat("alerta_global", 32'(alerta_global), 32'(e.glob));
  endtask

  task automatic paso(input logic [NC*W-1:0] t, input logic [NC-1:0] v, input logic [NC-1:0] b);
    temp_entrada = t; muestra_valida = v; borrar_falla = b;
    modelo_paso(t, v, b);
    sb_q.push_back(esperado());
    @(posedge clk); #1;
    if (sb_q.size() > 1) comparar(sb_q.pop_front());
  endtask

  task automatic uno(input int ch, input int temp, input logic b);
    logic [NC*W-1:0] t;
    t = '0;
    t[ch*W +: W] = W'(temp);
    paso(t, NC'(1) << ch, NC'(b) << ch);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) paso('0, '0, '0);
  endtask

  function automatic logic [NC*W-1:0] tv(input int a, input int b, input int c, input int d);
    return {W'(d), W'(c), W'(b), W'(a)};
  endfunction

  // Asserts reset for one edge; outputs must drop before any clock edge arrives.
  task automatic reset_dut();
    arst = 1'b1;
    #1;
    comparar('0);
    modelo_reset();
    sb_q.delete();
    sb_q.push_back('0);
    @(posedge clk); #1;
    arst = 1'b0;
  endtask

  int vals[14] = '{-1024, -41, -40, 10, 14, 15, 16, 17, 28, 29, 30, 31, 125, 126};
  int idx[NC];

  initial begin
    logic [NC*W-1:0] t;
    logic [NC-1:0]   v, b;
    temp_entrada = '0; muestra_valida = '0; borrar_falla = '0;
    modelo_reset();
    reset_dut();

    repeat (5) uno(0, 35, 1'b0);
    idle(3);
    uno(0, 20, 1'b0); idle(2);
    repeat (4) uno(0, 35, 1'b0);
    uno(0, 20, 1'b0); idle(3);

    repeat (5) uno(1, 10, 1'b0);
    idle(2);
    uno(1, 16, 1'b0); idle(2);
    uno(1, 17, 1'b0); idle(3);

    repeat (5) uno(2, 200, 1'b0);
    idle(2);
    uno(2, 200, 1'b1); paso('0, '0, 4'b0100); idle(2);
    uno(2, 20, 1'b1);  paso('0, '0, 4'b0100); idle(3);

    for (int k = 0; k < 10; k++) uno(3, (k % 2 == 1) ? 10 : 35, 1'b0);
    idle(3);

    repeat (5) paso(tv(35, 10, 20, 20), 4'b0011, 4'b0000);
    idle(3);

    repeat (3) paso(tv(35, 35, 35, 35), 4'b1111, 4'b0000);
    reset_dut();
    repeat (8) paso(tv(35, 35, 35, 35), 4'b1111, 4'b0000);
    idle(3);

    for (int c = 0; c < NC; c++) idx[c] = $urandom_range(13);
    for (int k = 0; k < 400; k++) begin
      t = '0; v = '0; b = '0;
      for (int c = 0; c < NC; c++) begin
        if ($urandom_range(7) == 0) idx[c] = $urandom_range(13);
        t[c*W +: W] = W'(vals[idx[c]]);
        v[c] = ($urandom_range(3) != 0);
        b[c] = ($urandom_range(15) == 0);
      end
      paso(t, v, b);
    end
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
